stream_reduce_dp: RTL and testbench

- Parametrised datapath-plus-control block: on `start` it captures a run of COUNT input samples from `a`, one per clock.
- It reduces the run according to a selectable mode (pass-last, sum, max, min) and presents the result on a registered output `z`, with busy/done/overflow status.
- Successor to the fixed 8-bit select/register datapath: width, run length and saturation are generalised, and a control FSM is added.
- Sits between the input sample source and downstream logic that consumes `z` on `done`.

---
 rtl/stream_reduce_dp.sv | 71 +++++++
 tb/tb_stream_reduce_dp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stream_reduce_dp.sv
// stream_reduce_dp: captures COUNT samples after start and reduces them by PASS/SUM/MAX/MIN
module stream_reduce_dp #(
   parameter int WIDTH = 8,
   parameter int COUNT = 4,
   parameter int SAT   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [1:0]       mode,
   input  logic             start,
   output logic [WIDTH-1:0] z,
   output logic             busy,
   output logic             done,
   output logic             ovf
);
   localparam int CW = $clog2(COUNT + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic [1:0]       mode_q;
   logic [WIDTH:0]   sum;
   logic             carry;
   logic [WIDTH-1:0] r;
   assign busy = state == RUN;
   assign done = state == DONE;
   // combine the incoming sample with the running accumulator
   always_comb begin
      sum   = {1'b0, acc} + {1'b0, a};
      carry = sum[WIDTH];
      r = mode_q == 2'd0 ? a :
          mode_q == 2'd1 ? ((carry && SAT != 0) ? '1 : sum[WIDTH-1:0]) :
          mode_q == 2'd2 ? ((a > acc) ? a : acc) :
                           ((a < acc) ? a : acc);
   end
   // control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         acc    <= '0;
         cnt    <= '0;
         mode_q <= '0;
         z      <= '0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mode_q == 2'd1 && carry) ovf <= 1'b1;
               acc <= r;
               if (cnt == CW'(COUNT - 1)) begin
                  z     <= r;
                  state <= DONE;
               end else cnt <= cnt + CW'(1);
            end
            default: begin
               if (start) begin
                  mode_q <= mode;
                  acc    <= a;
                  cnt    <= CW'(1);
                  ovf    <= 1'b0;
                  if (COUNT == 1) begin
                     z     <= a;
                     state <= DONE;
                  end else state <= RUN;
               end else state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_stream_reduce_dp.sv
// tb_stream_reduce_dp: directed and random checks of both SUM flavours against a reference model
module tb_stream_reduce_dp;
   logic       clk = 0;
   logic       reset;
   logic [7:0] a;
   logic [1:0] mode;
   logic       start;
   logic [7:0] z1, z0;
   logic       busy1, busy0, done1, done0, ovf1, ovf0;
   logic [7:0] ez1, ez0;
   int         checks = 0;
   int         fails = 0;

   stream_reduce_dp #(.WIDTH(8), .COUNT(4), .SAT(1)) dut_sat (
      .clk(clk), .reset(reset), .a(a), .mode(mode), .start(start),
      .z(z1), .busy(busy1), .done(done1), .ovf(ovf1));
   stream_reduce_dp #(.WIDTH(8), .COUNT(4), .SAT(0)) dut_wrap (
      .clk(clk), .reset(reset), .a(a), .mode(mode), .start(start),
      .z(z0), .busy(busy0), .done(done0), .ovf(ovf0));

   always #5 clk = ~clk;

   // reference: {ovf, z} for one run, from the whole sample set at once
   function automatic logic [8:0] model(input logic [1:0] m, input logic [7:0] s [4], input bit sat);
      int         t = 0;
      logic [7:0] mx = s[0];
      logic [7:0] mn = s[0];
      for (int i = 0; i < 4; i++) begin
         t += int'(s[i]);
         if (s[i] > mx) mx = s[i];
         if (s[i] < mn) mn = s[i];
      end
      case (m)
         2'd0: return {1'b0, s[3]};
         2'd1: return {t > 255, (sat && t > 255) ? 8'hFF : t[7:0]};
         2'd2: return {1'b0, mx};
         default: return {1'b0, mn};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
      checks++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic chk_status(input string tag, input logic b, input logic d);
      chk({tag, "_busy_sat"}, 9'(busy1), 9'(b));
      chk({tag, "_busy_wrap"}, 9'(busy0), 9'(b));
      chk({tag, "_done_sat"}, 9'(done1), 9'(d));
      chk({tag, "_done_wrap"}, 9'(done0), 9'(d));
   endtask

   // one full operation; returns in the DONE cycle so a caller may start again at once
   task automatic op(input logic [1:0] m, input logic [7:0] s [4], input bit noise);
      logic [8:0] e1, e0;
      e1 = model(m, s, 1'b1);
      e0 = model(m, s, 1'b0);
      start = 1'b1;
      mode  = m;
      a     = s[0];
      for (int i = 1; i < 4; i++) begin
         @(posedge clk); #1;
         chk_status("run", 1'b1, 1'b0);
         chk("z_hold_sat", 9'(z1), 9'(ez1));
         chk("z_hold_wrap", 9'(z0), 9'(ez0));
         start = noise;
         if (noise) mode = 2'd3;
         a = s[i];
      end
      @(posedge clk); #1;
      start = 1'b0;
      mode  = 2'd0;
      ez1 = e1[7:0];
      ez0 = e0[7:0];
      chk_status("fin", 1'b0, 1'b1);
      chk("z_sat", 9'(z1), 9'(ez1));
      chk("z_wrap", 9'(z0), 9'(ez0));
      chk("ovf_sat", 9'(ovf1), 9'(e1[8]));
      chk("ovf_wrap", 9'(ovf0), 9'(e0[8]));
   endtask

   task automatic idle();
      @(posedge clk); #1;
      chk_status("idle", 1'b0, 1'b0);
      chk("z_idle_sat", 9'(z1), 9'(ez1));
      chk("z_idle_wrap", 9'(z0), 9'(ez0));
   endtask

   initial begin
      logic [7:0] s [4];
      reset = 1'b0;
      start = 1'b1;
      a     = 8'hAA;
      mode  = 2'd1;
      ez1   = 8'h00;
      ez0   = 8'h00;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk_status("rst", 1'b0, 1'b0);
         chk("rst_z_sat", 9'(z1), 9'h000);
         chk("rst_z_wrap", 9'(z0), 9'h000);
         chk("rst_ovf_sat", 9'(ovf1), 9'h000);
         chk("rst_ovf_wrap", 9'(ovf0), 9'h000);
      end
      reset = 1'b1;
      start = 1'b0;
      idle();
      s = '{8'd10, 8'd20, 8'd30, 8'd40};
      op(2'd1, s, 1'b0);
      chk("sum_const", 9'(z1), 9'h064);
      idle();
      s = '{8'h80, 8'h80, 8'h10, 8'h01};
      op(2'd1, s, 1'b0);
      chk("sat_const", {ovf1, z1}, 9'h1FF);
      chk("wrap_const", {ovf0, z0}, 9'h111);
      idle();
      s = '{8'd5, 8'd200, 8'd17, 8'd3};
      op(2'd2, s, 1'b0);
      chk("max_const", 9'(z1), 9'h0C8);
      idle();
      op(2'd3, s, 1'b0);
      chk("min_const", 9'(z1), 9'h003);
      idle();
      op(2'd0, s, 1'b0);
      idle();
      s = '{8'd10, 8'd20, 8'd30, 8'd40};
      op(2'd1, s, 1'b1);
      chk("noise_const", 9'(z1), 9'h064);
      s = '{8'd1, 8'd2, 8'd3, 8'd4};
      op(2'd2, s, 1'b0);
      s = '{8'd9, 8'd250, 8'd7, 8'd8};
      op(2'd3, s, 1'b0);
      idle();
      start = 1'b1;
      mode  = 2'd1;
      a     = 8'd1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      ez1 = 8'h00;
      ez0 = 8'h00;
      chk_status("midrst", 1'b0, 1'b0);
      chk("midrst_z", 9'(z1), 9'h000);
      chk("midrst_ovf", 9'(ovf1), 9'h000);
      idle();
      s = '{8'd1, 8'd1, 8'd1, 8'd1};
      op(2'd1, s, 1'b0);
      chk("fresh_const", 9'(z1), 9'h004);
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 4; i++) s[i] = 8'($urandom_range(0, 255));
         op(2'($urandom_range(0, 3)), s, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 0) idle();
      end
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
